// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver for start / 8 data (LSB first) / even parity / stop frames.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority sampling.
// With the macro undefined, each sample point uses a single rx_s sample.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int HW = 2;
`else
  localparam int HW = 1;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  // hist_q[0] is rx_s one cycle ago (edge detect); hist_q[1] only exists for voting
  logic [HW-1:0]   hist_q, hist_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;

  logic            fall;
  logic            samp;

  // Synchronizer and rx_s history shift
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    hist_d    = {hist_q[0], rx_s_q};
`else
    hist_d    = rx_s_q;
`endif
  end

  // Start edge and the bit value seen at the current sample point
  always_comb begin
    fall = hist_q[0] & ~rx_s_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    // Window is the last three rx_s values ending at the advance cycle, so the
    // decision lands on the same cycle as the single-sample build.
    samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    samp = rx_s_q;
`endif
  end

  // Frame FSM: next state, bit timing, shift register and output updates
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          idx_d = '0;
          // a start bit that is already high again at mid-bit was a glitch
          state_d = samp ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d          = '0;
          shift_d[idx_q] = samp;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          par_d   = samp;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        // stay in STOP through the valid cycle so busy covers it, then leave
        // mid-stop-bit so an immediately following start edge is still caught
        if (data_valid_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == BIT_END) begin
          cnt_d        = '0;
          data_out_d   = shift_q;
          parity_err_d = par_q ^ (^shift_q);
          frame_err_d  = ~samp;
          data_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers; synchronizer resets to the idle-high level
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      hist_q       <= '1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      hist_q       <= hist_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clk per bit.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // valid-cycle capture
  int         vcnt = 0;
  int         busy_cycles = 0;
  logic [7:0] cap_d [0:63];
  logic       cap_p [0:63];
  logic       cap_f [0:63];
  logic       cap_b [0:63];

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (data_valid) begin
      cap_d[vcnt % 64] = data_out;
      cap_p[vcnt % 64] = parity_err;
      cap_f[vcnt % 64] = frame_err;
      cap_b[vcnt % 64] = busy;
      vcnt++;
    end
  end

  task automatic drive_bit(input logic b, input bit glitch);
    rx = b;
    for (int c = 0; c < CPB; c++) begin
      rx = (glitch && c == CPB/2) ? ~b : b;
      @(negedge clk);
    end
    rx = b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit glitch);
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    drive_bit(p, glitch);
    drive_bit(s, glitch);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
    checks++; if ({data_valid, parity_err, frame_err, busy} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b want 0000", {data_valid, parity_err, frame_err, busy}); end
    rst = 1'b0;
    idle(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_frame_ok(input logic [7:0] d, input bit glitch);
    int v0 = vcnt;
    send_frame(d, 1'b0, 1'b1, glitch);
    idle(4);
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL ok_valid_count got %0d want %0d", vcnt - v0, 1); end
    checks++; if (cap_d[v0 % 64] !== d) begin errors++; $display("FAIL ok_data got %h want %h", cap_d[v0 % 64], d); end
    checks++; if ({cap_p[v0 % 64], cap_f[v0 % 64]} !== 2'b00) begin errors++;
      $display("FAIL ok_errs got %b want 00", {cap_p[v0 % 64], cap_f[v0 % 64]}); end
    checks++; if (cap_b[v0 % 64] !== 1'b1) begin errors++; $display("FAIL ok_busy_at_valid got %b want 1", cap_b[v0 % 64]); end
    checks++; if (data_out !== d || busy !== 1'b0 || data_valid !== 1'b0) begin errors++;
      $display("FAIL ok_hold got data %h busy %b valid %b want %h 0 0", data_out, busy, data_valid, d); end
  endtask

  task automatic test_parity_err;
    int v0 = vcnt;
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    idle(4);
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL par_valid_count got %0d want 1", vcnt - v0); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL par_data got %h want 01", data_out); end
    checks++; if ({parity_err, frame_err} !== 2'b10) begin errors++;
      $display("FAIL par_errs got %b want 10", {parity_err, frame_err}); end
  endtask

  task automatic test_break;
    int v0 = vcnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL brk_valid_count got %0d want 1", vcnt - v0); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL brk_data got %h want 3c", data_out); end
    checks++; if ({parity_err, frame_err} !== 2'b01) begin errors++;
      $display("FAIL brk_errs got %b want 01", {parity_err, frame_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy_low_line got %b want 0", busy); end
    idle(40);
    checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL brk_release got %0d want 1", vcnt - v0); end
  endtask

  task automatic test_glitch_reject;
    int v0 = vcnt;
    int b0 = busy_cycles;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    checks++; if (busy_cycles == b0) begin errors++; $display("FAIL glitch_busy got %0d want >0", busy_cycles - b0); end
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL glitch_valid got %0d want 0", vcnt - v0); end
    checks++; if ({data_out, parity_err, frame_err, busy} !== {8'h3C, 3'b010}) begin errors++;
      $display("FAIL glitch_hold got %h %b%b%b want 3c 010", data_out, parity_err, frame_err, busy); end
  endtask

  task automatic test_back_to_back;
    int v0 = vcnt;
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(4);
    checks++; if (vcnt !== v0 + 2) begin errors++; $display("FAIL b2b_count got %0d want 2", vcnt - v0); end
    checks++; if (cap_d[v0 % 64] !== 8'h00 || cap_d[(v0 + 1) % 64] !== 8'hFF) begin errors++;
      $display("FAIL b2b_data got %h %h want 00 ff", cap_d[v0 % 64], cap_d[(v0 + 1) % 64]); end
    checks++; if ({cap_p[v0 % 64], cap_f[v0 % 64], cap_p[(v0 + 1) % 64], cap_f[(v0 + 1) % 64]} !== 4'b0000) begin errors++;
      $display("FAIL b2b_errs got %b want 0000",
               {cap_p[v0 % 64], cap_f[v0 % 64], cap_p[(v0 + 1) % 64], cap_f[(v0 + 1) % 64]}); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d = 8'h55;
    int v0 = vcnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(200);
    checks++; if (vcnt !== v0) begin errors++; $display("FAIL rstmid_valid got %0d want 0", vcnt - v0); end
    checks++; if (data_out !== 8'h00 || busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_state got %h busy %b want 00 0", data_out, busy); end
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    idle(4);
    checks++; if (vcnt !== v0 + 1 || data_out !== 8'h0F) begin errors++;
      $display("FAIL rstmid_next got count %0d data %h want 1 0f", vcnt - v0, data_out); end
    checks++; if ({parity_err, frame_err} !== 2'b00) begin errors++;
      $display("FAIL rstmid_errs got %b want 00", {parity_err, frame_err}); end
  endtask

  initial begin
    test_reset;
    test_frame_ok(8'hA5, 1'b0);
    test_parity_err;
    test_break;
    test_glitch_reject;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_MAJORITY_VOTE_EN
    test_frame_ok(8'hA5, 1'b1);
    test_frame_ok(8'h3C, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
